// File: rtl/mccpu_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: state codes,
// opcode/funct values, datapath select codes and the decoded-instruction record.
package mccpu_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_ALUWB  = 3'd3;
    localparam logic [2:0] ST_MEMRD  = 3'd4;
    localparam logic [2:0] ST_MEMWB  = 3'd5;
    localparam logic [2:0] ST_MEMWR  = 3'd6;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] GPR_RD  = 2'b00;
    localparam logic [1:0] GPR_RT  = 2'b01;
    localparam logic [1:0] GPR_R31 = 2'b10;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic         isBne;
        logic [3:0]   aluOp;
        logic         extOp;
        logic         aluSrc;
        logic         aluSrcA;
    } dec_t;

endpackage

// File: rtl/mccpu_decode.sv
// Combinational instruction classifier: maps the IR opcode/funct to an
// instruction class plus the ALU and immediate-extension controls.
module mccpu_decode
    import mccpu_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    // Anything not explicitly recognised falls through as ILLEGAL with all controls idle.
    always_comb begin
        o_dec     = '0;
        o_dec.cls = CLS_ILLEGAL;
        case (i_op)
            OP_RTYPE: begin
                o_dec.cls = CLS_RTYPE;
                case (i_funct)
                    F_ADD: o_dec.aluOp = ALU_ADD;
                    F_SUB: o_dec.aluOp = ALU_SUB;
                    F_AND: o_dec.aluOp = ALU_AND;
                    F_OR:  o_dec.aluOp = ALU_OR;
                    F_SLT: o_dec.aluOp = ALU_SLT;
                    F_SLL: begin
                        o_dec.aluOp   = ALU_SLL;
                        o_dec.aluSrcA = 1'b1;
                    end
                    F_SRL: begin
                        o_dec.aluOp   = ALU_SRL;
                        o_dec.aluSrcA = 1'b1;
                    end
                    F_JR:    o_dec.cls = CLS_JR;
                    default: o_dec.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                o_dec.cls    = CLS_ITYPE;
                o_dec.aluOp  = ALU_ADD;
                o_dec.extOp  = 1'b1;
                o_dec.aluSrc = 1'b1;
            end
            OP_ORI: begin
                o_dec.cls    = CLS_ITYPE;
                o_dec.aluOp  = ALU_OR;
                o_dec.aluSrc = 1'b1;
            end
            OP_LUI: begin
                o_dec.cls    = CLS_ITYPE;
                o_dec.aluOp  = ALU_LUI;
                o_dec.aluSrc = 1'b1;
            end
            OP_LW: begin
                o_dec.cls    = CLS_LOAD;
                o_dec.aluOp  = ALU_ADD;
                o_dec.extOp  = 1'b1;
                o_dec.aluSrc = 1'b1;
            end
            OP_SW: begin
                o_dec.cls    = CLS_STORE;
                o_dec.aluOp  = ALU_ADD;
                o_dec.extOp  = 1'b1;
                o_dec.aluSrc = 1'b1;
            end
            OP_BEQ: begin
                o_dec.cls   = CLS_BRANCH;
                o_dec.aluOp = ALU_SUB;
                o_dec.extOp = 1'b1;
            end
            OP_BNE: begin
                o_dec.cls   = CLS_BRANCH;
                o_dec.aluOp = ALU_SUB;
                o_dec.extOp = 1'b1;
                o_dec.isBne = 1'b1;
            end
            OP_J:    o_dec.cls = CLS_JUMP;
            OP_JAL:  o_dec.cls = CLS_JAL;
            default: o_dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mccpu_ctrl.sv
// Multicycle control sequencer: state register, next-state logic and the
// per-state datapath strobes for the shared-register MIPS datapath.
module mccpu_ctrl
    import mccpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic       ALUSrcA,
    output logic       ALUSrc,
    output logic [1:0] NPCOp,
    output logic [1:0] WDSel,
    output logic [1:0] GPRSel,
    output logic       instr_done,
    output logic       illegal,
    output logic [2:0] state
);

    logic [2:0] r_state;
    logic       r_illegal;
    logic [2:0] w_next;
    dec_t       w_dec;
    logic       w_pcWrite, w_irWrite, w_regWrite, w_memRead, w_memWrite;
    logic [1:0] w_npcOp, w_wdSel, w_gprSel;
    logic       w_aluActive;
    logic       w_illegalSet;

    mccpu_decode u_decode (
        .i_op    (Op),
        .i_funct (Funct),
        .o_dec   (w_dec)
    );

    assign w_illegalSet = (r_state == ST_DECODE) && (w_dec.cls == CLS_ILLEGAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_illegalSet)
                r_illegal <= 1'b1;
        end
    end

    // Illegal instructions retire in DECODE as a plain PC+4 so the CPU keeps running.
    always_comb begin
        w_next     = r_state;
        w_pcWrite  = 1'b0;
        w_irWrite  = 1'b0;
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_npcOp    = NPC_PC4;
        w_wdSel    = WD_ALU;
        w_gprSel   = GPR_RD;
        case (r_state)
            ST_FETCH: begin
                w_irWrite = 1'b1;
                w_next    = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_dec.cls)
                    CLS_JUMP: begin
                        w_pcWrite = 1'b1;
                        w_npcOp   = NPC_JUMP;
                        w_next    = ST_FETCH;
                    end
                    CLS_JAL: begin
                        w_pcWrite  = 1'b1;
                        w_npcOp    = NPC_JUMP;
                        w_regWrite = 1'b1;
                        w_gprSel   = GPR_R31;
                        w_wdSel    = WD_PC4;
                        w_next     = ST_FETCH;
                    end
                    CLS_JR: begin
                        w_pcWrite = 1'b1;
                        w_npcOp   = NPC_JR;
                        w_next    = ST_FETCH;
                    end
                    CLS_ILLEGAL: begin
                        w_pcWrite = 1'b1;
                        w_next    = ST_FETCH;
                    end
                    default: w_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (w_dec.cls)
                    CLS_BRANCH: begin
                        w_pcWrite = 1'b1;
                        if (w_dec.isBne ^ Zero)
                            w_npcOp = NPC_BRANCH;
                        w_next = ST_FETCH;
                    end
                    CLS_LOAD:  w_next = ST_MEMRD;
                    CLS_STORE: w_next = ST_MEMWR;
                    default:   w_next = ST_ALUWB;
                endcase
            end
            ST_ALUWB: begin
                w_regWrite = 1'b1;
                w_gprSel   = (w_dec.cls == CLS_ITYPE) ? GPR_RT : GPR_RD;
                w_pcWrite  = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_MEMRD: begin
                w_memRead = 1'b1;
                if (mem_ready)
                    w_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                w_regWrite = 1'b1;
                w_wdSel    = WD_MEM;
                w_gprSel   = GPR_RT;
                w_pcWrite  = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_MEMWR: begin
                w_memWrite = 1'b1;
                if (mem_ready) begin
                    w_pcWrite = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            default: w_next = ST_FETCH;
        endcase
    end

    // Reset gates everything combinationally so strobes drop without waiting for a clock.
    assign w_aluActive = (r_state != ST_FETCH) && !rst;

    assign PCWrite    = w_pcWrite  & ~rst;
    assign IRWrite    = w_irWrite  & ~rst;
    assign RegWrite   = w_regWrite & ~rst;
    assign MemRead    = w_memRead  & ~rst;
    assign MemWrite   = w_memWrite & ~rst;
    assign NPCOp      = rst ? NPC_PC4 : w_npcOp;
    assign WDSel      = rst ? WD_ALU  : w_wdSel;
    assign GPRSel     = rst ? GPR_RD  : w_gprSel;
    assign ALUOp      = w_aluActive ? w_dec.aluOp : ALU_NOP;
    assign EXTOp      = w_aluActive & w_dec.extOp;
    assign ALUSrc     = w_aluActive & w_dec.aluSrc;
    assign ALUSrcA    = w_aluActive & w_dec.aluSrcA;
    assign instr_done = PCWrite;
    assign illegal    = r_illegal;
    assign state      = r_state;

endmodule
